dcache_port_sequencer: RTL and testbench

// Shares one D$ request port of the cache-subsystem harness between NumReq requesters (e.g. PTW, load, store agents).
// - Round-robin arbitration; the winner's request is latched and replayed on the cache port under req/gnt handshake.
// - Tracks in-flight loads in an ID FIFO so in-order cache_rvalid_i is routed back to the issuing requester.
// - Provides a drain/flush sequence for tests that flush the cache with no loads outstanding.

---
 rtl/dcache_port_sequencer_if.sv | 27 ++
 rtl/dcache_port_sequencer.sv | 150 +++++++++++++++
 tb/tb_dcache_port_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_port_sequencer_if.sv
// Cache-side request/response bus of the D$ port sequencer.
// master: the sequencer (drives req/addr/we/wdata/be, receives gnt/rvalid/rdata).
// slave:  the D$ port (accepts requests, returns in-order load data).
//   req    request valid, held with a stable payload until gnt
//   addr   request address
//   we     1 = store, 0 = load
//   wdata  store data
//   be     byte enables
//   gnt    request accepted this cycle
//   rvalid load data valid (in order of accepted loads)
//   rdata  load data
interface dcache_port_sequencer_if #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64
) ();
  logic                   req;
  logic [AddrWidth-1:0]   addr;
  logic                   we;
  logic [DataWidth-1:0]   wdata;
  logic [DataWidth/8-1:0] be;
  logic                   gnt;
  logic                   rvalid;
  logic [DataWidth-1:0]   rdata;

  modport master (output req, addr, we, wdata, be, input gnt, rvalid, rdata);
  modport slave  (input req, addr, we, wdata, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/dcache_port_sequencer.sv
// Shares one D$ request port between NumReq requesters.
// A round-robin arbiter picks a requester in IDLE, latches its payload and replays it on the
// cache port (REQ) until cache gnt. Accepted loads push the requester ID into a FIFO so the
// in-order cache responses are steered back to the issuer. A flush drains all loads and pulses
// flush_ack_o.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_*_i             packed per-requester valid/addr/we/wdata/be
//   req_gnt_o           one-hot pulse: request latched
//   rsp_valid_o/rdata_o one-hot load response, data broadcast
//   cache_io            master side of the D$ bus
//   flush_i/flush_ack_o drain request level / completion pulse
//   outstanding_o       in-flight load count
//   spurious_o          sticky: response seen with no load in flight
module dcache_port_sequencer #(
  parameter int unsigned NumReq         = 3,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned BeWidth       = DataWidth / 8,
  localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NumReq-1:0]           req_valid_i,
  input  logic [NumReq*AddrWidth-1:0] req_addr_i,
  input  logic [NumReq-1:0]           req_we_i,
  input  logic [NumReq*DataWidth-1:0] req_wdata_i,
  input  logic [NumReq*BeWidth-1:0]   req_be_i,
  output logic [NumReq-1:0]           req_gnt_o,
  output logic [NumReq-1:0]           rsp_valid_o,
  output logic [DataWidth-1:0]        rsp_rdata_o,
  dcache_port_sequencer_if.master     cache_io,
  input  logic                        flush_i,
  output logic                        flush_ack_o,
  output logic [CntWidth-1:0]         outstanding_o,
  output logic                        spurious_o
);
  localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

  state_e               state_q;
  logic [IdxW-1:0]      rr_q, id_q;
  logic [AddrWidth-1:0] addr_q;
  logic                 we_q;
  logic [DataWidth-1:0] wdata_q;
  logic [BeWidth-1:0]   be_q;
  logic [IdxW-1:0]      fifo_q [MaxOutstanding];
  logic [PtrW-1:0]      wptr_q, rptr_q;
  logic [CntWidth-1:0]  cnt_q;
  logic                 spurious_q;

  logic [NumReq-1:0] elig;
  logic              found, grant, push, pop;
  logic [IdxW-1:0]   win;
  int unsigned       idx;

  // Round-robin pick: first eligible index at or after rr_q, wrapping. Loads are only eligible
  // while the registered count leaves room in the ID FIFO.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      elig[i] = req_valid_i[i] && (req_we_i[i] || (cnt_q < CntWidth'(MaxOutstanding)));
    end
    for (int unsigned k = 0; k < NumReq; k++) begin
      idx = (32'(rr_q) + k) % NumReq;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = IdxW'(idx);
      end
    end
  end

  // Grant is gated by reset so outputs stay quiet while rst_i is held.
  assign grant = (state_q == StIdle) && !flush_i && found && !rst_i;
  assign push  = (state_q == StReq) && cache_io.gnt && !we_q;
  assign pop   = cache_io.rvalid && (cnt_q != '0);

  always_comb begin
    req_gnt_o   = '0;
    rsp_valid_o = '0;
    if (grant) req_gnt_o[win] = 1'b1;
    if (pop) rsp_valid_o[fifo_q[rptr_q]] = 1'b1;
  end

  assign rsp_rdata_o    = pop ? cache_io.rdata : '0;
  assign flush_ack_o    = (state_q == StDrain) && (cnt_q == '0);
  assign outstanding_o  = cnt_q;
  assign spurious_o     = spurious_q;
  assign cache_io.req   = (state_q == StReq);
  assign cache_io.addr  = addr_q;
  assign cache_io.we    = we_q;
  assign cache_io.wdata = wdata_q;
  assign cache_io.be    = be_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      rr_q       <= '0;
      id_q       <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      spurious_q <= 1'b0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (flush_i) begin
            state_q <= StDrain;
          end else if (grant) begin
            state_q <= StReq;
            id_q    <= win;
            addr_q  <= req_addr_i[win*AddrWidth +: AddrWidth];
            we_q    <= req_we_i[win];
            wdata_q <= req_wdata_i[win*DataWidth +: DataWidth];
            be_q    <= req_be_i[win*BeWidth +: BeWidth];
            rr_q    <= (32'(win) == NumReq - 1) ? '0 : win + 1'b1;
          end
        end
        StReq: begin
          if (cache_io.gnt) state_q <= flush_i ? StDrain : StIdle;
        end
        StDrain: begin
          if (cnt_q == '0) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      // When full, the pop reads the head slot before the push overwrites it.
      if (push) begin
        fifo_q[wptr_q] <= id_q;
        wptr_q         <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (push && !pop) cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;

      if (cache_io.rvalid && (cnt_q == '0)) spurious_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dcache_port_sequencer.sv
module tb_dcache_port_sequencer;
  logic         clk = 1'b0;
  logic         rst_i;
  logic [2:0]   req_valid, req_we, req_gnt, rsp_valid;
  logic [191:0] req_addr, req_wdata;
  logic [23:0]  req_be;
  logic [63:0]  rsp_rdata;
  logic         flush, flush_ack, spurious;
  logic [2:0]   outstanding;
  int           total = 0;
  int           bad = 0;

  dcache_port_sequencer_if #(.AddrWidth(64), .DataWidth(64)) cif ();

  dcache_port_sequencer #(
    .NumReq(3), .AddrWidth(64), .DataWidth(64), .MaxOutstanding(4)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_wdata_i(req_wdata), .req_be_i(req_be), .req_gnt_o(req_gnt),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .cache_io(cif.master),
    .flush_i(flush), .flush_ack_o(flush_ack), .outstanding_o(outstanding),
    .spurious_o(spurious)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    logic        rst;
    logic [2:0]  valid;
    logic [2:0]  we;
    logic        cgnt;
    logic        rvalid;
    logic [63:0] rdata;
    logic        flush;
    logic [2:0]  e_gnt;
    logic [2:0]  e_rsp;
    logic        e_creq;
    logic [2:0]  e_out;
    logic        e_ack;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic rst, logic [2:0] valid, logic [2:0] we, logic cgnt,
                              logic rvalid, logic [63:0] rdata, logic fl, logic [2:0] e_gnt,
                              logic [2:0] e_rsp, logic e_creq, logic [2:0] e_out, logic e_ack);
    vec_t v;
    v = '{rst, valid, we, cgnt, rvalid, rdata, fl, e_gnt, e_rsp, e_creq, e_out, e_ack};
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid  = '0;
    req_we     = '0;
    flush      = 1'b0;
    cif.gnt    = 1'b0;
    cif.rvalid = 1'b0;
    cif.rdata  = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle_inputs();
    next_cyc();
    rst_i = 1'b0;
  endtask

  int n_gnt, n_ack;

  initial begin
    rst_i     = 1'b1;
    req_addr  = {64'h1200, 64'h1100, 64'h1000};
    req_wdata = {64'hC2C2, 64'hB1B1, 64'hA0A0};
    req_be    = {8'hF0, 8'h0F, 8'hFF};
    idle_inputs();

    // Three loads from reset, then responses in order.
    add(1, 3'b111, 0, 1, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0);
    add(0, 3'b111, 0, 1, 0, 0, 0, 3'b001, 3'b000, 0, 0, 0);
    add(0, 3'b110, 0, 1, 0, 0, 0, 3'b000, 3'b000, 1, 0, 0);
    add(0, 3'b110, 0, 1, 0, 0, 0, 3'b010, 3'b000, 0, 1, 0);
    add(0, 3'b100, 0, 1, 0, 0, 0, 3'b000, 3'b000, 1, 1, 0);
    add(0, 3'b100, 0, 1, 0, 0, 0, 3'b100, 3'b000, 0, 2, 0);
    add(0, 3'b000, 0, 1, 0, 0, 0, 3'b000, 3'b000, 1, 2, 0);
    add(0, 3'b000, 0, 1, 1, 64'hD0, 0, 3'b000, 3'b001, 0, 3, 0);
    add(0, 3'b000, 0, 1, 1, 64'hD1, 0, 3'b000, 3'b010, 0, 2, 0);
    add(0, 3'b000, 0, 1, 1, 64'hD2, 0, 3'b000, 3'b100, 0, 1, 0);
    add(0, 3'b000, 0, 1, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0);
    // Fill to 4, then push and pop together across the pointer wrap.
    add(1, 3'b111, 0, 1, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0);
    add(0, 3'b111, 0, 1, 0, 0, 0, 3'b001, 3'b000, 0, 0, 0);
    add(0, 3'b111, 0, 1, 0, 0, 0, 3'b000, 3'b000, 1, 0, 0);
    add(0, 3'b111, 0, 1, 0, 0, 0, 3'b010, 3'b000, 0, 1, 0);
    add(0, 3'b111, 0, 1, 0, 0, 0, 3'b000, 3'b000, 1, 1, 0);
    add(0, 3'b111, 0, 1, 0, 0, 0, 3'b100, 3'b000, 0, 2, 0);
    add(0, 3'b111, 0, 1, 0, 0, 0, 3'b000, 3'b000, 1, 2, 0);
    add(0, 3'b111, 0, 1, 0, 0, 0, 3'b001, 3'b000, 0, 3, 0);
    add(0, 3'b111, 0, 1, 0, 0, 0, 3'b000, 3'b000, 1, 3, 0);
    add(0, 3'b111, 0, 1, 1, 64'hE0, 0, 3'b000, 3'b001, 0, 4, 0);
    add(0, 3'b111, 0, 1, 0, 0, 0, 3'b010, 3'b000, 0, 3, 0);
    add(0, 3'b111, 0, 1, 1, 64'hE1, 0, 3'b000, 3'b010, 1, 3, 0);
    add(0, 3'b111, 0, 1, 0, 0, 0, 3'b100, 3'b000, 0, 3, 0);
    add(0, 3'b111, 0, 1, 1, 64'hE2, 0, 3'b000, 3'b100, 1, 3, 0);
    add(0, 3'b111, 0, 1, 0, 0, 0, 3'b001, 3'b000, 0, 3, 0);
    add(0, 3'b111, 0, 1, 1, 64'hE3, 0, 3'b000, 3'b001, 1, 3, 0);
    add(0, 3'b111, 0, 1, 0, 0, 0, 3'b010, 3'b000, 0, 3, 0);
    add(0, 3'b111, 0, 1, 1, 64'hE4, 0, 3'b000, 3'b010, 1, 3, 0);
    add(0, 3'b000, 0, 1, 1, 64'hE5, 0, 3'b000, 3'b100, 0, 3, 0);
    add(0, 3'b000, 0, 1, 1, 64'hE6, 0, 3'b000, 3'b001, 0, 2, 0);
    add(0, 3'b000, 0, 1, 1, 64'hE7, 0, 3'b000, 3'b010, 0, 1, 0);
    add(0, 3'b000, 0, 1, 0, 0, 0, 3'b000, 3'b000, 0, 0, 0);

    next_cyc();
    foreach (vecs[i]) begin
      rst_i      = vecs[i].rst;
      req_valid  = vecs[i].valid;
      req_we     = vecs[i].we;
      cif.gnt    = vecs[i].cgnt;
      cif.rvalid = vecs[i].rvalid;
      cif.rdata  = vecs[i].rdata;
      flush      = vecs[i].flush;
      #4;
      chk($sformatf("row%0d_gnt", i), 64'(req_gnt), 64'(vecs[i].e_gnt));
      chk($sformatf("row%0d_rsp", i), 64'(rsp_valid), 64'(vecs[i].e_rsp));
      chk($sformatf("row%0d_rdata", i), rsp_rdata,
          (vecs[i].e_rsp != 3'b000) ? vecs[i].rdata : 64'h0);
      chk($sformatf("row%0d_creq", i), 64'(cif.req), 64'(vecs[i].e_creq));
      chk($sformatf("row%0d_out", i), 64'(outstanding), 64'(vecs[i].e_out));
      chk($sformatf("row%0d_ack", i), 64'(flush_ack), 64'(vecs[i].e_ack));
      if (vecs[i].rst) chk($sformatf("row%0d_addr", i), cif.addr, 64'h0);
      next_cyc();
    end

    // Load backpressure: only req 1 loads, no responses.
    do_reset();
    req_valid = 3'b010;
    cif.gnt   = 1'b1;
    n_gnt     = 0;
    for (int c = 0; c < 8; c++) begin
      #4;
      if (req_gnt == 3'b010) n_gnt++;
      next_cyc();
    end
    chk("bp_grants", 64'(n_gnt), 64'd4);
    #4;
    chk("bp_full_cnt", 64'(outstanding), 64'd4);
    chk("bp_full_nognt", 64'(req_gnt), 64'd0);
    next_cyc();
    req_valid = 3'b011;
    req_we    = 3'b001;
    #4;
    chk("bp_store_gnt", 64'(req_gnt), 64'b001);
    next_cyc();
    req_valid = 3'b010;
    req_we    = 3'b000;
    #4;
    chk("bp_store_we", 64'(cif.we), 64'd1);
    chk("bp_store_wdata", cif.wdata, 64'hA0A0);
    chk("bp_store_be", 64'(cif.be), 64'hFF);
    next_cyc();
    cif.rvalid = 1'b1;
    cif.rdata  = 64'hF00D;
    #4;
    chk("bp_pop_nognt", 64'(req_gnt), 64'd0);
    chk("bp_pop_rsp", 64'(rsp_valid), 64'b010);
    chk("bp_store_nopush", 64'(outstanding), 64'd4);
    next_cyc();
    cif.rvalid = 1'b0;
    #4;
    chk("bp_after_pop_gnt", 64'(req_gnt), 64'b010);
    chk("bp_after_pop_cnt", 64'(outstanding), 64'd3);
    next_cyc();

    // cache_gnt_i stall for 5 REQ cycles.
    do_reset();
    req_valid = 3'b001;
    #4;
    chk("stall_gnt0", 64'(req_gnt), 64'b001);
    next_cyc();
    req_valid = 3'b100;
    for (int c = 0; c < 5; c++) begin
      #4;
      chk($sformatf("stall%0d_creq", c), 64'(cif.req), 64'd1);
      chk($sformatf("stall%0d_addr", c), cif.addr, 64'h1000);
      chk($sformatf("stall%0d_nognt", c), 64'(req_gnt), 64'd0);
      next_cyc();
    end
    cif.gnt = 1'b1;
    #4;
    chk("stall_6th_creq", 64'(cif.req), 64'd1);
    next_cyc();
    cif.gnt = 1'b0;
    #4;
    chk("stall_done_cnt", 64'(outstanding), 64'd1);
    chk("stall_next_gnt", 64'(req_gnt), 64'b100);
    next_cyc();

    // Flush during REQ with two loads outstanding.
    do_reset();
    cif.gnt   = 1'b1;
    req_valid = 3'b011;
    next_cyc();
    req_valid = 3'b010;
    next_cyc();
    next_cyc();
    req_valid = 3'b100;
    next_cyc();
    #4;
    chk("fl_pre_cnt", 64'(outstanding), 64'd2);
    chk("fl_pre_gnt", 64'(req_gnt), 64'b100);
    next_cyc();
    req_valid = 3'b001;
    flush     = 1'b1;
    n_gnt     = 0;
    n_ack     = 0;
    #4;
    chk("fl_req_creq", 64'(cif.req), 64'd1);
    if (req_gnt != 0) n_gnt++;
    if (flush_ack) n_ack++;
    next_cyc();
    for (int c = 0; c < 3; c++) begin
      cif.rvalid = 1'b1;
      cif.rdata  = 64'h50 + 64'(c);
      #4;
      chk($sformatf("fl_cnt%0d", c), 64'(outstanding), 64'(3 - c));
      chk($sformatf("fl_rsp%0d", c), 64'(rsp_valid), 64'(1 << c));
      if (req_gnt != 0) n_gnt++;
      if (flush_ack) n_ack++;
      next_cyc();
    end
    cif.rvalid = 1'b0;
    flush      = 1'b0;
    #4;
    chk("fl_ack_cycle", 64'(flush_ack), 64'd1);
    if (req_gnt != 0) n_gnt++;
    if (flush_ack) n_ack++;
    next_cyc();
    req_valid = 3'b000;
    #4;
    if (flush_ack) n_ack++;
    chk("fl_ack_count", 64'(n_ack), 64'd1);
    chk("fl_no_grants", 64'(n_gnt), 64'd0);
    next_cyc();

    // Reset in REQ with two loads in flight.
    do_reset();
    cif.gnt   = 1'b1;
    req_valid = 3'b011;
    next_cyc();
    req_valid = 3'b010;
    next_cyc();
    next_cyc();
    req_valid = 3'b100;
    next_cyc();
    #4;
    chk("rm_pre_cnt", 64'(outstanding), 64'd2);
    next_cyc();
    rst_i = 1'b1;
    #4;
    chk("rm_gnt", 64'(req_gnt), 64'd0);
    chk("rm_creq", 64'(cif.req), 64'd0);
    chk("rm_addr", cif.addr, 64'd0);
    chk("rm_we_be", {cif.wdata, 3'b0, cif.we, cif.be[3:0]}, 64'd0);
    chk("rm_cnt", 64'(outstanding), 64'd0);
    chk("rm_misc", {61'd0, flush_ack, spurious, |rsp_valid}, 64'd0);
    next_cyc();
    rst_i      = 1'b0;
    req_valid  = 3'b000;
    cif.gnt    = 1'b0;
    cif.rvalid = 1'b1;
    cif.rdata  = 64'h77;
    #4;
    chk("rm_late_rsp", 64'(rsp_valid), 64'd0);
    chk("rm_late_rdata", rsp_rdata, 64'd0);
    next_cyc();
    cif.rvalid = 1'b0;
    #4;
    chk("rm_spurious", 64'(spurious), 64'd1);
    next_cyc();
    next_cyc();
    #4;
    chk("rm_spurious_sticky", 64'(spurious), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
